// File: rtl/frame_tracker.sv
// rtl/frame_tracker.sv - VGA frame/line tracker with dump window, end-of-run flag and heartbeat
module frame_tracker #(
    parameter bit VS_POL = 1'b0,
    parameter bit HS_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        VGA_VS,
    input  logic        VGA_HS,
    input  logic [31:0] start_frame,
    input  logic [31:0] stop_frame,
    input  logic [31:0] max_frames,
    output logic [31:0] frame_cnt,
    output logic        frame_pulse,
    output logic [15:0] line_cnt,
    output logic        dump_on,
    output logic        finish,
    output logic        led
);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } dump_state_t;

    logic        vs_s1, vs_s2, vs_h;
    logic        hs_s1, hs_s2, hs_h;
    logic        vs_edge, hs_edge;
    logic [15:0] line_acc;
    logic        first_q;
    dump_state_t state_q, state_d;

    // Sync chains idle at the inactive level so reset release never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_s1 <= ~VS_POL;
            vs_s2 <= ~VS_POL;
            vs_h  <= ~VS_POL;
            hs_s1 <= ~HS_POL;
            hs_s2 <= ~HS_POL;
            hs_h  <= ~HS_POL;
        end else begin
            vs_s1 <= VGA_VS;
            vs_s2 <= vs_s1;
            vs_h  <= vs_s2;
            hs_s1 <= VGA_HS;
            hs_s2 <= hs_s1;
            hs_h  <= hs_s2;
        end
    end

    assign vs_edge = (vs_s2 == VS_POL) && (vs_h == ~VS_POL);
    assign hs_edge = (hs_s2 == HS_POL) && (hs_h == ~HS_POL);

    // An HS edge landing with the frame edge belongs to the new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt   <= 32'd0;
            frame_pulse <= 1'b0;
            line_cnt    <= 16'd0;
            line_acc    <= 16'd0;
        end else begin
            frame_pulse <= vs_edge;
            if (vs_edge) begin
                frame_cnt <= frame_cnt + 32'd1;
                line_cnt  <= line_acc;
                line_acc  <= hs_edge ? 16'd1 : 16'd0;
            end else if (hs_edge && (line_acc != 16'hFFFF)) begin
                line_acc <= line_acc + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q <= 1'b1;
            state_q <= ST_WAIT;
        end else begin
            first_q <= 1'b0;
            state_q <= state_d;
        end
    end

    // Transitions look at the frame number already advanced alongside frame_pulse.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT: begin
                if (frame_pulse) begin
                    if (frame_cnt == stop_frame) begin
                        state_d = ST_OFF;
                    end else if (frame_cnt == start_frame) begin
                        state_d = ST_ON;
                    end
                end else if (first_q && (start_frame == 32'd0) && (stop_frame != 32'd0)) begin
                    state_d = ST_ON;
                end
            end
            ST_ON: begin
                if (frame_pulse && (frame_cnt == stop_frame)) begin
                    state_d = ST_OFF;
                end
            end
            default: state_d = state_q;
        endcase
    end

    assign dump_on = (state_q == ST_ON);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            finish <= 1'b0;
            led    <= 1'b0;
        end else if (frame_pulse) begin
            if ((max_frames != 32'd0) && (frame_cnt == max_frames)) begin
                finish <= 1'b1;
            end
            if (frame_cnt[4:0] == 5'd0) begin
                led <= ~led;
            end
        end
    end

endmodule

// File: tb/tb_frame_tracker.sv
// tb/tb_frame_tracker.sv - randomized self-checking bench for frame_tracker
module tb_frame_tracker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vga_vs, vga_hs;
    logic [31:0] start_frame, stop_frame, max_frames;
    logic [31:0] frame_cnt;
    logic        frame_pulse;
    logic [15:0] line_cnt;
    logic        dump_on, finish, led;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_cnt;
    logic [31:0] m_n;
    int          m_acc;
    logic [15:0] m_line;
    logic        m_led;

    always #5 clk = ~clk;

    frame_tracker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .VGA_VS     (vga_vs),
        .VGA_HS     (vga_hs),
        .start_frame(start_frame),
        .stop_frame (stop_frame),
        .max_frames (max_frames),
        .frame_cnt  (frame_cnt),
        .frame_pulse(frame_pulse),
        .line_cnt   (line_cnt),
        .dump_on    (dump_on),
        .finish     (finish),
        .led        (led)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic exp_dump();
        if (start_frame == 0 && stop_frame != 0) return m_n < stop_frame;
        return (start_frame != 0) && (start_frame != stop_frame) &&
               (m_n >= start_frame) && (m_n < stop_frame);
    endfunction

    function automatic logic exp_finish();
        return (max_frames != 0) && (m_n >= max_frames);
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_n    = 0;
        m_acc  = 0;
        m_line = 0;
        m_led  = 0;
    endtask

    task automatic do_reset(input logic [31:0] s, input logic [31:0] p, input logic [31:0] mx);
        @(negedge clk);
        rst_n       = 1'b0;
        vga_vs      = 1'b1;
        vga_hs      = 1'b1;
        start_frame = s;
        stop_frame  = p;
        max_frames  = mx;
        model_reset();
        #1;
        check_eq("rst_frame_cnt", frame_cnt, 0);
        check_eq("rst_line_cnt", 32'(line_cnt), 0);
        check_eq("rst_outs", {29'd0, dump_on, finish, led}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rel_dump_pre", 32'(dump_on), 0);
        @(posedge clk);
        #1;
        check_eq("rel_dump", 32'(dump_on), 32'(exp_dump()));
        check_eq("rel_pulse", 32'(frame_pulse), 0);
        @(negedge clk);
    endtask

    task automatic hs_pulse();
        vga_hs = 1'b0;
        repeat (2) @(negedge clk);
        vga_hs = 1'b1;
        repeat (2) @(negedge clk);
        if (m_acc < 65535) m_acc++;
    endtask

    task automatic send_frame(input int lines, input bit coin);
        int lat;
        int highs;
        for (int i = 0; i < lines; i++) hs_pulse();
        vga_vs = 1'b0;
        if (coin) vga_hs = 1'b0;
        m_line = 16'(m_acc);
        m_acc  = coin ? 1 : 0;
        m_cnt  = m_cnt + 1;
        m_n    = m_n + 1;
        if (m_cnt[4:0] == 5'd0) m_led = ~m_led;
        lat   = 0;
        highs = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (frame_pulse) begin
                highs++;
                if (lat == 0) begin
                    lat = i;
                    check_eq("pulse_frame_cnt", frame_cnt, m_cnt);
                end
            end
        end
        check_eq("pulse_latency", 32'(lat), 3);
        check_eq("pulse_width", 32'(highs), 1);
        @(negedge clk);
        vga_vs = 1'b1;
        vga_hs = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("frame_cnt", frame_cnt, m_cnt);
        check_eq("line_cnt", 32'(line_cnt), 32'(m_line));
        check_eq("dump_on", 32'(dump_on), 32'(exp_dump()));
        check_eq("finish", 32'(finish), 32'(exp_finish()));
        check_eq("led", 32'(led), 32'(m_led));
    endtask

    initial begin
        int pulses;
        rst_n       = 1'b0;
        vga_vs      = 1'b1;
        vga_hs      = 1'b1;
        start_frame = 0;
        stop_frame  = 0;
        max_frames  = 0;

        // line counting, including an HS edge coincident with VS
        do_reset(100, 200, 0);
        for (int f = 0; f < 3; f++) send_frame(262, 1'b0);
        send_frame(5, 1'b1);
        send_frame(7, 1'b0);

        // dump window 5..8, randomized line counts, heartbeat and no finish
        do_reset(5, 8, 0);
        for (int f = 0; f < 40; f++)
            send_frame(int'($urandom_range(0, 12)), $urandom_range(0, 3) == 0);

        // window open from reset
        do_reset(0, 2, 0);
        for (int f = 0; f < 3; f++) send_frame(int'($urandom_range(0, 6)), 1'b0);

        // start == stop never opens; finish at frame 3
        do_reset(4, 4, 3);
        for (int f = 0; f < 6; f++) send_frame(int'($urandom_range(0, 6)), 1'b0);

        // asynchronous reset while the window is open and finish is set
        do_reset(0, 10, 1);
        send_frame(2, 1'b0);
        send_frame(3, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_dump", 32'(dump_on), 0);
        check_eq("async_finish", 32'(finish), 0);
        check_eq("async_frame_cnt", frame_cnt, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (frame_pulse) pulses++;
        end
        check_eq("no_pulse_on_release", 32'(pulses), 0);
        check_eq("rerun_dump", 32'(dump_on), 32'(exp_dump()));
        @(negedge clk);
        send_frame(1, 1'b0);

        // frame counter wraparound
        do_reset(0, 0, 0);
        force dut.frame_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.frame_cnt;
        m_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        send_frame(3, 1'b0);
        send_frame(2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
